// File: rtl/tmds_gearbox.sv
// -----------------------------------------------------------------------------
// tmds_gearbox
//
// Serialises one 10-bit TMDS symbol per lane per pixel period into OUT_W bits
// per lane per clk_shift cycle, LSB first. It sits between the TMDS encoders
// and the ODDR/output pins. A one-deep symbol buffer decouples the producer.
// When no symbol is waiting at a symbol boundary, an idle symbol is inserted
// and the event is counted.
//
// Parameters
//   NCH    lane count; lane NCH-1 is the TMDS clock lane, the rest carry data
//   C_DDR  0: SDR (OUT_W=1, 10 cycles/symbol), 1: DDR (OUT_W=2, 5 cycles/symbol)
//   SYM_W  symbol width; must be 10
//
// Ports
//   clk_shift      shift clock (only clock)
//   rst            asynchronous active-high reset
//   sym_in         lane k symbol = sym_in[10k+9:10k]
//   sym_valid      sym_in is valid
//   sym_ready      buffer can accept sym_in this cycle (independent of sym_valid)
//   out_bits       lane k = out_bits[OUT_W*k +: OUT_W], bit0 = first bit out
//   underflow      one-cycle pulse: an idle symbol was inserted
//   underflow_cnt  saturating count of inserted idle symbols
//
// Optional feature macro: TMDS_GEARBOX_CLKGEN_EN
//   When defined, the clock lane is generated locally (0000011111 every
//   symbol) and the clock-lane bits of sym_in are ignored.
// -----------------------------------------------------------------------------
module tmds_gearbox #(
  parameter int NCH   = 4,
  parameter int C_DDR = 1,
  parameter int SYM_W = 10
) (
  input  logic                                   clk_shift,
  input  logic                                   rst,
  input  logic [NCH*SYM_W-1:0]                   sym_in,
  input  logic                                   sym_valid,
  output logic                                   sym_ready,
  output logic [NCH*((C_DDR != 0) ? 2 : 1)-1:0]  out_bits,
  output logic                                   underflow,
  output logic [7:0]                             underflow_cnt
);

  localparam int OUT_W = (C_DDR != 0) ? 2 : 1;
  localparam int P     = (C_DDR != 0) ? 5 : 10;
  localparam int CNT_W = 4;

  localparam logic [SYM_W-1:0] DATA_IDLE = 10'b1101010100;  // CTL0=CTL1=0
  localparam logic [SYM_W-1:0] CLK_IDLE  = 10'b0000011111;

  generate
    if (SYM_W != 10) begin : g_sym_w_check
      $error("tmds_gearbox: SYM_W must be 10");
    end
  endgenerate

  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 full_reg, full_next;
  logic [NCH*SYM_W-1:0] buf_reg, buf_next;
  logic                 underflow_reg;
  logic [7:0]           underflow_cnt_reg;
  logic                 boundary;
  logic                 accept;

  assign boundary = (cnt_reg == CNT_W'(P - 1));
  // Ready depends only on registered state: the buffer is either empty or
  // being drained into the shift registers on this very edge.
  assign sym_ready = !full_reg || boundary;
  assign accept    = sym_valid && sym_ready;

  always_comb begin
    cnt_next  = boundary ? '0 : cnt_reg + CNT_W'(1);
    full_next = full_reg;
    buf_next  = buf_reg;
    if (boundary && full_reg) begin
      full_next = 1'b0;
    end
    // Applied after the drain so that a drain and a refill on the same edge
    // leave the buffer full with the new symbol.
    if (accept) begin
      full_next = 1'b1;
      buf_next  = sym_in;
    end
  end

  always_ff @(posedge clk_shift or posedge rst) begin
    if (rst) begin
      cnt_reg           <= '0;
      full_reg          <= 1'b0;
      buf_reg           <= '0;
      underflow_reg     <= 1'b0;
      underflow_cnt_reg <= '0;
    end else begin
      cnt_reg       <= cnt_next;
      full_reg      <= full_next;
      buf_reg       <= buf_next;
      underflow_reg <= boundary && !full_reg;
      if (boundary && !full_reg && (underflow_cnt_reg != 8'hFF)) begin
        underflow_cnt_reg <= underflow_cnt_reg + 8'd1;
      end
    end
  end

  assign underflow     = underflow_reg;
  assign underflow_cnt = underflow_cnt_reg;

  // Per-lane shift register and output register.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      localparam logic [SYM_W-1:0] LANE_IDLE = (gi == NCH - 1) ? CLK_IDLE : DATA_IDLE;

      logic [SYM_W-1:0] sreg_reg, sreg_next;
      logic [SYM_W-1:0] load_sym;
      logic [OUT_W-1:0] out_reg;

      always_comb begin
        load_sym = full_reg ? buf_reg[gi*SYM_W +: SYM_W] : LANE_IDLE;
`ifdef TMDS_GEARBOX_CLKGEN_EN
        if (gi == NCH - 1) begin
          load_sym = CLK_IDLE;
        end
`endif
        sreg_next = boundary ? load_sym : (sreg_reg >> OUT_W);
      end

      always_ff @(posedge clk_shift or posedge rst) begin
        if (rst) begin
          sreg_reg <= LANE_IDLE;
          out_reg  <= '0;
        end else begin
          sreg_reg <= sreg_next;
          out_reg  <= sreg_reg[OUT_W-1:0];
        end
      end

      assign out_bits[gi*OUT_W +: OUT_W] = out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_gearbox.sv
// -----------------------------------------------------------------------------
// tb_tmds_gearbox
//
// Drives a DDR instance and an SDR instance (both NCH=4) from one directed
// sequence with random symbol contents. A reference model works at stream
// level: after the k-th clock edge following reset, a lane shows slice
// (k-1) mod P of the symbol chosen at the most recent boundary (edge number a
// multiple of P), the very first symbol being the idle symbol left by reset.
// A boundary takes the waiting buffered symbol or, if none, an idle symbol
// and counts an underflow.
// -----------------------------------------------------------------------------
module tb_tmds_gearbox;

  localparam logic [9:0]  DATA_IDLE = 10'b1101010100;
  localparam logic [9:0]  CLK_IDLE  = 10'b0000011111;
  localparam logic [39:0] IDLE_ALL  = {CLK_IDLE, DATA_IDLE, DATA_IDLE, DATA_IDLE};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] sym_in_d = '0, sym_in_s = '0;
  logic        sym_valid_d = 1'b0, sym_valid_s = 1'b0;
  logic        sym_ready_d, sym_ready_s;
  logic [7:0]  out_bits_d;
  logic [3:0]  out_bits_s;
  logic        underflow_d, underflow_s;
  logic [7:0]  underflow_cnt_d, underflow_cnt_s;

  always #5 clk = ~clk;

  tmds_gearbox #(.NCH(4), .C_DDR(1), .SYM_W(10)) u_ddr (
    .clk_shift     (clk),
    .rst           (rst),
    .sym_in        (sym_in_d),
    .sym_valid     (sym_valid_d),
    .sym_ready     (sym_ready_d),
    .out_bits      (out_bits_d),
    .underflow     (underflow_d),
    .underflow_cnt (underflow_cnt_d)
  );

  tmds_gearbox #(.NCH(4), .C_DDR(0), .SYM_W(10)) u_sdr (
    .clk_shift     (clk),
    .rst           (rst),
    .sym_in        (sym_in_s),
    .sym_valid     (sym_valid_s),
    .sym_ready     (sym_ready_s),
    .out_bits      (out_bits_s),
    .underflow     (underflow_s),
    .underflow_cnt (underflow_cnt_s)
  );

  // Reference model state, index 0 = DDR instance, 1 = SDR instance.
  int          n_checks = 0;
  int          n_fail   = 0;
  int          p_m [2]  = '{5, 10};
  int          w_m [2]  = '{2, 1};
  int          edge_m [2];
  logic [39:0] emit_m [2];
  logic [39:0] bufv_m [2];
  bit          full_m [2];
  int          ucnt_m [2];
  logic        uflag_m [2];
  logic [7:0]  out_m [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      edge_m[d]  = 0;
      emit_m[d]  = IDLE_ALL;
      bufv_m[d]  = '0;
      full_m[d]  = 1'b0;
      ucnt_m[d]  = 0;
      uflag_m[d] = 1'b0;
      out_m[d]   = '0;
    end
  endtask

  function automatic bit model_ready(input int d);
    return !full_m[d] || (((edge_m[d] + 1) % p_m[d]) == 0);
  endfunction

  // One rising edge of the model for instance d.
  task automatic model_edge(input int d, input bit acc, input logic [39:0] sym);
    int          k, s;
    logic [39:0] nsym;
    logic [9:0]  lane_sym;
    logic [7:0]  o;
    k = edge_m[d] + 1;
    s = (k - 1) % p_m[d];
    o = '0;
    for (int l = 0; l < 4; l++) begin
      lane_sym = emit_m[d][l*10 +: 10];
      o = o | (8'(int'(lane_sym >> (s * w_m[d])) & ((1 << w_m[d]) - 1)) << (l * w_m[d]));
    end
    out_m[d]   = o;
    uflag_m[d] = 1'b0;
    if ((k % p_m[d]) == 0) begin
      if (full_m[d]) begin
        nsym      = bufv_m[d];
        full_m[d] = 1'b0;
      end else begin
        nsym       = IDLE_ALL;
        uflag_m[d] = 1'b1;
        if (ucnt_m[d] < 255) ucnt_m[d]++;
      end
`ifdef TMDS_GEARBOX_CLKGEN_EN
      nsym[39:30] = CLK_IDLE;
`endif
      emit_m[d] = nsym;
    end
    if (acc) begin
      bufv_m[d] = sym;
      full_m[d] = 1'b1;
      $display("[%0t] %s accept sym=%h ucnt=%0d", $time, (d == 0) ? "ddr" : "sdr", sym, ucnt_m[d]);
    end
    edge_m[d] = k;
  endtask

  // One clock cycle: drive, check ready, clock, update model, check outputs.
  task automatic cycle(input logic vd, input logic [39:0] sd, input logic vs, input logic [39:0] ss);
    bit acc_d, acc_s;
    sym_valid_d = vd;
    sym_in_d    = sd;
    sym_valid_s = vs;
    sym_in_s    = ss;
    #1;
    chk("ddr_ready", 32'(sym_ready_d), 32'(model_ready(0)));
    chk("sdr_ready", 32'(sym_ready_s), 32'(model_ready(1)));
    acc_d = vd && model_ready(0);
    acc_s = vs && model_ready(1);
    @(posedge clk);
    model_edge(0, acc_d, sd);
    model_edge(1, acc_s, ss);
    #1;
    chk("ddr_out", 32'(out_bits_d), 32'(out_m[0]));
    chk("sdr_out", 32'(out_bits_s), 32'(out_m[1][3:0]));
    chk("ddr_uflow", 32'(underflow_d), 32'(uflag_m[0]));
    chk("sdr_uflow", 32'(underflow_s), 32'(uflag_m[1]));
    chk("ddr_ucnt", 32'(underflow_cnt_d), 32'(ucnt_m[0]));
    chk("sdr_ucnt", 32'(underflow_cnt_s), 32'(ucnt_m[1]));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ddr_out"}, 32'(out_bits_d), 32'd0);
    chk({tag, "_sdr_out"}, 32'(out_bits_s), 32'd0);
    chk({tag, "_ddr_ready"}, 32'(sym_ready_d), 32'd1);
    chk({tag, "_ddr_uflow"}, 32'(underflow_d), 32'd0);
    chk({tag, "_ddr_ucnt"}, 32'(underflow_cnt_d), 32'd0);
    chk({tag, "_sdr_ucnt"}, 32'(underflow_cnt_s), 32'd0);
  endtask

  initial begin
    logic [39:0] r, rs;
    bit          found;

    // Step 1: power-on reset.
    model_reset();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // Step 2: no input for 20 cycles -> idle symbols, 4 DDR underflows.
    for (int i = 0; i < 20; i++) cycle(1'b0, rnd40(), 1'b0, rnd40());
    chk("idle20_ddr_ucnt", 32'(underflow_cnt_d), 32'd4);

    // Step 3: steady one-per-symbol DDR producer (lane 0 = 1010110011),
    // SDR fed 2AA on lane 0 back-to-back.
    for (int i = 0; i < 120; i++) begin
      r  = rnd40();
      rs = rnd40();
      r[9:0]  = 10'b1010110011;
      rs[9:0] = 10'h2AA;
      if (((edge_m[0] + 1) % 5) == 1) chk("steady_ready", 32'(sym_ready_d), 32'd1);
      cycle(((edge_m[0] + 1) % 5) == 1, r, 1'b1, rs);
    end

    // Step 4: backpressure, valid held high on both instances.
    for (int i = 0; i < 60; i++) cycle(1'b1, rnd40(), 1'b1, rnd40());

    // Step 5: random valid, random contents.
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), rnd40(), 1'($urandom_range(0, 1)), rnd40());
    end

    // Step 6: long starvation -> counter saturates, pulses continue.
    for (int i = 0; i < 1550; i++) cycle(1'b0, rnd40(), 1'b0, rnd40());
    chk("sat_ddr_ucnt", 32'(underflow_cnt_d), 32'd255);

    // Step 7: reset mid-symbol (cnt=2) with the buffer full; clock lane fed 3FF.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      r = rnd40();
      r[39:30] = 10'h3FF;
      cycle(1'b1, r, 1'b1, rnd40());
      if ((edge_m[0] % 5) == 2 && full_m[0]) found = 1'b1;
    end
    chk("find_cnt2_full", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 25; i++) begin
      r = rnd40();
      r[39:30] = 10'h3FF;
      cycle(i >= 12, r, 1'b0, rnd40());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
